// File: rtl/mult_pkg.sv
// Shared constants for the 4-bit shift-and-add multiplier: the FSM state encoding
// and the datapath widths.
package mult_pkg;

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] LATCH = 2'd1;
    localparam logic [1:0] CALC  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int MULT_W = 4;
    localparam int PROD_W = 8;

    localparam logic [1:0] CNT_INIT = 2'd3;

endpackage

// File: rtl/mult_step.sv
// One shift-and-add step: if bit k of the multiplier is set, the multiplicand is
// shifted left by k and added to the accumulator.
module mult_step
    import mult_pkg::*;
(
    input  logic [PROD_W-1:0] acc,
    input  logic [MULT_W-1:0] a_reg,
    input  logic [MULT_W-1:0] b_reg,
    input  logic [1:0]        k,
    output logic [PROD_W-1:0] acc_next
);

    logic [PROD_W-1:0] addend;

    always_comb begin
        addend   = PROD_W'(a_reg) << k;
        acc_next = acc;
        if (b_reg[k])
            acc_next = acc + addend;
    end

endmodule

// File: rtl/mult_datapath.sv
// Datapath behind the multiplier control FSM: latches operands, runs four partial-product
// steps and publishes the product with a one-cycle valid pulse. Signed operands are
// supported when MULT_DATAPATH_SIGNED_EN is defined.
module mult_datapath
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        state,
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic [1:0]        count,
    output logic [PROD_W-1:0] product,
    output logic              valid,
    output logic              busy
);

    logic [MULT_W-1:0] a_reg;
    logic [MULT_W-1:0] b_reg;
    logic [PROD_W-1:0] acc;
    logic [1:0]        count_reg;
    logic [PROD_W-1:0] product_reg;
    logic              valid_reg;
    logic [1:0]        k;
    logic [PROD_W-1:0] acc_next;
    logic [MULT_W-1:0] a_load;
    logic [MULT_W-1:0] b_load;
    logic [PROD_W-1:0] result;

`ifdef MULT_DATAPATH_SIGNED_EN
    logic neg_reg;

    // A 4-bit magnitude covers -8 because the register is read as unsigned.
    function automatic logic [MULT_W-1:0] mag(input logic signed [MULT_W-1:0] v);
        return v[MULT_W-1] ? MULT_W'(~v + 1'b1) : v;
    endfunction

    function automatic logic [PROD_W-1:0] negate(input logic [PROD_W-1:0] v);
        return PROD_W'(~v + 1'b1);
    endfunction

    assign a_load = mag(a);
    assign b_load = mag(b);
    assign result = neg_reg ? negate(acc) : acc;
`else
    assign a_load = a;
    assign b_load = b;
    assign result = acc;
`endif

    assign k = CNT_INIT - count_reg;

    mult_step u_step (
        .acc      (acc),
        .a_reg    (a_reg),
        .b_reg    (b_reg),
        .k        (k),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            count_reg   <= '0;
            product_reg <= '0;
            valid_reg   <= 1'b0;
`ifdef MULT_DATAPATH_SIGNED_EN
            neg_reg     <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            case (state)
                LATCH: begin
                    a_reg     <= a_load;
                    b_reg     <= b_load;
                    acc       <= '0;
                    count_reg <= CNT_INIT;
`ifdef MULT_DATAPATH_SIGNED_EN
                    neg_reg   <= a[MULT_W-1] ^ b[MULT_W-1];
`endif
                end
                CALC: begin
                    acc <= acc_next;
                    if (count_reg != 2'd0)
                        count_reg <= count_reg - 2'd1;
                end
                DONE: begin
                    product_reg <= result;
                    valid_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign count   = count_reg;
    assign product = product_reg;
    assign valid   = valid_reg;
    assign busy    = (state != INIT);

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: drives the FSM state sequence directly and checks products
// through a scoreboard queue filled at LATCH and drained on each valid pulse.
module tb_mult_datapath;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  state = INIT;
    logic [3:0]  a = '0;
    logic [3:0]  b = '0;
    logic [1:0]  count;
    logic [7:0]  product;
    logic        valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_exp = '0;

    mult_datapath dut (
        .clk     (clk),
        .rst     (rst),
        .state   (state),
        .a       (a),
        .b       (b),
        .count   (count),
        .product (product),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
`ifdef MULT_DATAPATH_SIGNED_EN
        logic signed [7:0] sx, sy;
        sx = {{4{x[3]}}, x};
        sy = {{4{y[3]}}, y};
        return 8'(sx * sy);
`else
        return 8'({4'b0, x} * {4'b0, y});
`endif
    endfunction

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic [1:0] st, input logic [3:0] ai, input logic [3:0] bi,
                         input logic r);
        @(posedge clk);
        #1;
        state = st;
        a     = ai;
        b     = bi;
        rst   = r;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            pulses++;
            if (sb_q.size() == 0)
                check_eq("valid_unexpected", valid, 0);
            else
                check_eq("product", product, sb_q.pop_front());
        end
    end

    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi, input bit scramble,
                          input bit with_init);
        logic [7:0] e;
        e = model(ai, bi);
        if (with_init) begin
            drive(INIT, ai, bi, 1'b1);
            check_eq("busy_init", busy, 0);
        end
        drive(LATCH, ai, bi, 1'b1);
        check_eq("busy_latch", busy, 1);
        sb_q.push_back(e);
        exp_pulses++;
        for (int i = 0; i < 4; i++) begin
            if (scramble)
                drive(CALC, 4'h0, 4'h0, 1'b1);
            else
                drive(CALC, ai, bi, 1'b1);
            check_eq("count_calc", count, 3 - i);
        end
        drive(DONE, 4'($urandom), 4'($urandom), 1'b1);
        check_eq("valid_in_done", valid, 0);
        check_eq("busy_done", busy, 1);
        drive(INIT, 4'($urandom), 4'($urandom), 1'b1);
        check_eq("valid_pulse", valid, 1);
        drive(INIT, 4'($urandom), 4'($urandom), 1'b1);
        check_eq("valid_single", valid, 0);
        check_eq("product_hold", product, e);
        last_exp = e;
    endtask

    initial begin
        drive(INIT, 4'h0, 4'h0, 1'b0);
        drive(INIT, 4'h0, 4'h0, 1'b0);
        check_eq("rst_count", count, 0);
        check_eq("rst_product", product, 0);
        check_eq("rst_valid", valid, 0);

        run_op(4'd3, 4'd5, 1'b0, 1'b1);
        run_op(4'd15, 4'd15, 1'b0, 1'b1);
        run_op(4'd0, 4'd9, 1'b0, 1'b1);
        run_op(4'd9, 4'd0, 1'b0, 1'b1);
        run_op(4'd6, 4'd7, 1'b1, 1'b1);

        // Restart: LATCH arrives while count is still nonzero.
        drive(INIT, 4'd1, 4'd1, 1'b1);
        drive(LATCH, 4'd1, 4'd1, 1'b1);
        drive(CALC, 4'd1, 4'd1, 1'b1);
        drive(CALC, 4'd1, 4'd1, 1'b1);
        check_eq("count_before_restart", count, 2);
        run_op(4'd5, 4'd3, 1'b0, 1'b0);

`ifdef MULT_DATAPATH_SIGNED_EN
        run_op(4'hD, 4'd5, 1'b0, 1'b1);
        run_op(4'h8, 4'h8, 1'b0, 1'b1);
        run_op(4'd7, 4'h9, 1'b0, 1'b1);
`endif
        for (int n = 0; n < 4; n++)
            run_op(4'($urandom), 4'($urandom), n[0], 1'b1);

        // Reset during the second CALC cycle discards the run.
        run_op(4'd11, 4'd13, 1'b0, 1'b1);
        drive(INIT, 4'd2, 4'd3, 1'b1);
        drive(LATCH, 4'd2, 4'd3, 1'b1);
        drive(CALC, 4'd2, 4'd3, 1'b1);
        drive(CALC, 4'd2, 4'd3, 1'b0);
        drive(INIT, 4'd2, 4'd3, 1'b1);
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_product", product, 0);
        check_eq("mid_rst_valid", valid, 0);
        for (int i = 0; i < 6; i++)
            drive(INIT, 4'd2, 4'd3, 1'b1);
        check_eq("post_rst_product", product, 0);

        check_eq("queue_empty", sb_q.size(), 0);
        check_eq("pulse_count", pulses, exp_pulses);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
